seq_word_serializer: RTL and testbench
======================================

# seq_word_serializer

Parallel-to-serial front end for the serial sequence detector. Accepts WIDTH-bit words over a valid/ready handshake and presents them one bit per enabled cycle on `x`, the detector's serial input. One pending-word register allows back-to-back words with no gap between them. An optional parity bit can be appended to each word.

## Interface
- `WIDTH`, default 10: data bits per word, minimum 2.
- `MSB_FIRST`, default 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low; clears all state immediately.
- `load_valid`  in  1  upstream offers `load_data`.
- `load_data`  in  WIDTH  word to serialize.
- `load_ready`  out  1  block can accept a word this cycle.
- `en`  in  1  bit strobe; the serial position advances only on cycles with en=1.
- `x`  out  1  current serial bit.
- `x_valid`  out  1  `x` carries a real bit this cycle.
- `last`  out  1  `x` is the final bit of the current frame.
- `busy`  out  1  shifter or pending register is occupied.

## Operation
- Storage: shift register `shreg` with `active` flag and bit counter `cnt`; pending register `pend` with `pend_v`.
- FSM states are IDLE (`active`=0) and SHIFT (`active`=1).
- Accept occurs when `load_valid & load_ready`. `load_ready = !pend_v`.
- Accept in IDLE loads the word into `shreg`, sets `cnt`=0 and moves to SHIFT. `pend` is untouched.
- Accept in SHIFT loads the word into `pend` and sets `pend_v`=1.
- `x` = current bit of `shreg`. `x_valid = active & en`. `last = x_valid & (cnt == FRAME-1)`. FRAME is WIDTH, or WIDTH+1 when parity is enabled.
- In SHIFT with en=1 and not last: shift `shreg` by one toward the output end and increment `cnt`.
- In SHIFT with en=1 and last, and `pend_v`=1: move `pend` into `shreg`, clear `pend_v`, set `cnt`=0 and stay in SHIFT.
- In SHIFT with en=1 and last, and `pend_v`=0: return to IDLE.
- If an accept occurs on the same edge as a last bit with `pend_v`=0, the new word loads directly into `shreg`, giving a gapless continuation.
- In SHIFT with en=0: hold all state. `x` stays stable; `x_valid`=0.
- `busy = active | pend_v`.

## Timing
- Reset values: `x`=0, `x_valid`=0, `last`=0, `load_ready`=1, `busy`=0. Internally `active`=0, `pend_v`=0, `cnt`=0, `shreg`=0.
- Latency: a word accepted at edge N presents its first bit in the cycle following N, with `x_valid`=1 if en=1.
- Throughput: one bit per en cycle. There is no idle bit between consecutive words while `pend_v`=1 or a same-edge accept occurs.
- When `pend_v`=1, `load_ready`=0. It returns to 1 the cycle after `pend` transfers into `shreg`.
- Reset asserted mid-word: the partial word and the pending word are discarded and `x_valid` drops immediately (asynchronous). After release, the block is in IDLE with `load_ready`=1.
- `load_data` is sampled only on the accept edge; later changes have no effect.

## Configuration
- `SER_PARITY_EN` defined: FRAME = WIDTH+1. After the data bits, one even-parity bit (XOR of the word) is shifted out. `last` marks the parity bit.
- `SER_PARITY_EN` undefined: FRAME = WIDTH, no parity logic, and `last` marks data bit WIDTH-1 or bit 0 depending on `MSB_FIRST`.

## Structure
- Shared package `seq_pkg` holds:
  - the state enum {IDLE, SHIFT};
  - `SEQ_WORD_W` = 10 as the default WIDTH;
  - the counter width function `$clog2(WIDTH+1)`.
- The pending register plus handshake forms a natural sub-module, `seq_word_holdreg` (one-entry buffer: valid, data, ready). The shifter and FSM stay in the top module.

## Test plan
- Reset, then accept 10'b0001111010 with MSB_FIRST=1 and en=1 held -> `x` = 0,0,0,1,1,1,1,0,1,0 on consecutive cycles; `last`=1 only on the 10th; then `busy`=0.
- Accept 10'h3FF, then accept 10'h000 while shifting -> `load_ready`=0 after the second accept; 20 consecutive `x_valid` cycles (ten 1s then ten 0s) with no gap.
- Toggle en 1,0,1,0 during word 10'b1010101010 -> `cnt` advances only on en=1; `x` holds while `x_valid`=0; total of 10 valid bits.
- Assert rst low at bit 4 of word 10'h155 -> `x_valid`, `busy` and `last` go 0 immediately; `load_ready`=1; the next word starts from bit 0.
- MSB_FIRST=0 with word 10'b0000000001 -> first `x`=1, followed by nine 0s.
- With `SER_PARITY_EN` defined, word 10'b0000000111 -> 10 data bits then parity bit 1; `last` is on the 11th bit.

Source files
------------

// File: rtl/seq_word_serializer_pkg.sv
// Shared types and sizing helpers for the sequence-detector serializer front end.
package seq_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  localparam int unsigned SEQ_WORD_W = 10;

  // Bit-counter width able to index a frame of up to w+1 bits
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_word_serializer_if.sv
// Load handshake and serial output bundle between upstream, serializer and detector.
interface seq_word_serializer_if
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_WORD_W
);
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             en;
  logic             x;
  logic             x_valid;
  logic             last;
  logic             busy;

  modport master (output load_valid, load_data, en,
                  input  load_ready, x, x_valid, last, busy);
  modport slave  (input  load_valid, load_data, en,
                  output load_ready, x, x_valid, last, busy);
endinterface

// File: rtl/seq_word_serializer_holdreg.sv
// One-entry pending-word buffer; ready whenever the entry is empty.
module seq_word_holdreg
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (push) begin
      valid <= 1'b1;
      data  <= push_data;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

  assign ready = !valid;

endmodule

// File: rtl/seq_word_serializer.sv
// Word-to-bit serializer feeding the sequence detector's x input.
// Define SER_PARITY_EN to append an even-parity bit to every word.
module seq_word_serializer
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH     = SEQ_WORD_W,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  seq_word_serializer_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
`ifdef SER_PARITY_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif

  // Place the parity bit at the tail so it leaves after the data bits
  function automatic logic [FRAME-1:0] build_frame(input logic [WIDTH-1:0] d);
`ifdef SER_PARITY_EN
    if (MSB_FIRST) return {d, ^d};
    else           return {^d, d};
`else
    return d;
`endif
  endfunction

  state_e           state_q, state_d;
  logic [FRAME-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active, accept, last_c, push, pop;
  logic             pend_v, pend_ready;
  logic [WIDTH-1:0] pend_data;

  assign active      = (state_q == SHIFT);
  assign accept      = bus.load_valid & pend_ready;
  assign last_c      = active & bus.en & (cnt_q == CNT_W'(FRAME - 1));
  // Accepts on the final bit with an empty pending slot bypass the buffer
  assign push        = accept & active & !last_c;
  assign pop         = last_c & pend_v;

  assign bus.load_ready = pend_ready;
  assign bus.x_valid    = active & bus.en;
  assign bus.last       = last_c;
  assign bus.busy       = active | pend_v;
  assign bus.x          = MSB_FIRST ? shreg_q[FRAME-1] : shreg_q[0];

  seq_word_holdreg #(.WIDTH(WIDTH)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.load_data),
    .pop       (pop),
    .ready     (pend_ready),
    .valid     (pend_v),
    .data      (pend_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = build_frame(bus.load_data);
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.en) begin
          if (!last_c) begin
            shreg_d = MSB_FIRST ? {shreg_q[FRAME-2:0], 1'b0}
                                : {1'b0, shreg_q[FRAME-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
          end else if (pend_v) begin
            shreg_d = build_frame(pend_data);
            cnt_d   = '0;
          end else if (accept) begin
            shreg_d = build_frame(bus.load_data);
            cnt_d   = '0;
          end else begin
            shreg_d = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_word_serializer.sv
// Directed bench for seq_word_serializer: vector table plus multi-cycle corner sequences.
module tb_seq_word_serializer;

`ifdef SER_PARITY_EN
  localparam int FR = 11;
`else
  localparam int FR = 10;
`endif

  typedef struct {
    logic       lv;
    logic [9:0] ld;
    logic       en;
    logic       x;
    logic       xv;
    logic       last;
    logic       lr;
    logic       busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vecs[$];

  logic [FR-1:0] pat_a, pat_ones, pat_zero, pat_d, pat_e, pat_l;

  always #5 clk = ~clk;

  seq_word_serializer_if #(.WIDTH(10)) bus ();
  seq_word_serializer_if #(.WIDTH(10)) bus_l ();

  seq_word_serializer #(.WIDTH(10), .MSB_FIRST(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  seq_word_serializer #(.WIDTH(10), .MSB_FIRST(1'b0)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic lv, input logic [9:0] ld, input logic en,
                     input logic x, input logic xv, input logic last,
                     input logic lr, input logic busy);
    vec_t v;
    v.lv = lv; v.ld = ld; v.en = en; v.x = x; v.xv = xv;
    v.last = last; v.lr = lr; v.busy = busy;
    vecs.push_back(v);
  endtask

  // One full frame with en held high; pattern read first-bit-leftmost
  task automatic add_frame(input logic [FR-1:0] pat, input logic lv_first,
                           input logic lv_last, input logic [9:0] ld,
                           input logic lr_first, input logic lr_rest);
    for (int k = 0; k < FR; k++) begin
      add((k == 0) ? lv_first : ((k == FR - 1) ? lv_last : 1'b0), ld, 1'b1,
          pat[FR-1-k], 1'b1, (k == FR - 1), (k == 0) ? lr_first : lr_rest, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
`ifdef SER_PARITY_EN
    pat_a    = {10'b0001111010, 1'b1};
    pat_ones = {10'b1111111111, 1'b0};
    pat_zero = {10'b0000000000, 1'b0};
    pat_d    = {10'b0000000111, 1'b1};
    pat_e    = {10'b1010101010, 1'b1};
    pat_l    = {10'b1000000000, 1'b1};
`else
    pat_a    = 10'b0001111010;
    pat_ones = 10'b1111111111;
    pat_zero = 10'b0000000000;
    pat_d    = 10'b0000000111;
    pat_e    = 10'b1010101010;
    pat_l    = 10'b1000000000;
`endif
    bus.load_valid = 1'b0; bus.load_data = '0; bus.en = 1'b0;
    bus_l.load_valid = 1'b0; bus_l.load_data = '0; bus_l.en = 1'b0;

    // Reset values while rst is held low
    #12;
    chk("rst.x", bus.x, 1'b0);
    chk("rst.x_valid", bus.x_valid, 1'b0);
    chk("rst.last", bus.last, 1'b0);
    chk("rst.load_ready", bus.load_ready, 1'b1);
    chk("rst.busy", bus.busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Single word; load_data garbage after the accept must be ignored
    add(1'b1, 10'b0001111010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    add_frame(pat_a, 1'b0, 1'b0, 10'h3FF, 1'b1, 1'b1);
    add(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Back-to-back through the pending register
    add(1'b1, 10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    add_frame(pat_ones, 1'b1, 1'b0, 10'h000, 1'b1, 1'b0);
    add_frame(pat_zero, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1);
    add(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Same-edge accept on the last bit with empty pending slot
    add(1'b1, 10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    add_frame(pat_ones, 1'b0, 1'b1, 10'h000, 1'b1, 1'b1);
    add_frame(pat_zero, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1);
    add(1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Word with odd population (parity bit 1 when enabled)
    add(1'b1, 10'b0000000111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    add_frame(pat_d, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1);
    add(1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus.load_valid = vecs[i].lv;
      bus.load_data  = vecs[i].ld;
      bus.en         = vecs[i].en;
      #1;
      chk($sformatf("vec%0d.x", i), bus.x, vecs[i].x);
      chk($sformatf("vec%0d.x_valid", i), bus.x_valid, vecs[i].xv);
      chk($sformatf("vec%0d.last", i), bus.last, vecs[i].last);
      chk($sformatf("vec%0d.load_ready", i), bus.load_ready, vecs[i].lr);
      chk($sformatf("vec%0d.busy", i), bus.busy, vecs[i].busy);
    end

    // en toggling 1,0,1,0: x holds across disabled cycles
    @(negedge clk);
    bus.load_valid = 1'b1; bus.load_data = 10'b1010101010; bus.en = 1'b1;
    for (int k = 0; k < FR; k++) begin
      @(negedge clk);
      bus.load_valid = 1'b0; bus.en = 1'b1;
      #1;
      chk($sformatf("en%0d.x", k), bus.x, pat_e[FR-1-k]);
      chk($sformatf("en%0d.x_valid", k), bus.x_valid, 1'b1);
      chk($sformatf("en%0d.last", k), bus.last, (k == FR - 1));
      if (k < FR - 1) begin
        @(negedge clk);
        bus.en = 1'b0;
        #1;
        chk($sformatf("en%0d.hold_x", k), bus.x, pat_e[FR-2-k]);
        chk($sformatf("en%0d.hold_x_valid", k), bus.x_valid, 1'b0);
        chk($sformatf("en%0d.hold_last", k), bus.last, 1'b0);
      end
    end
    @(negedge clk);
    bus.en = 1'b1;
    #1;
    chk("en.done_busy", bus.busy, 1'b0);
    chk("en.done_x_valid", bus.x_valid, 1'b0);

    // Reset mid-word with a pending word queued
    @(negedge clk);
    bus.load_valid = 1'b1; bus.load_data = 10'h155; bus.en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.load_valid = (k == 1); bus.load_data = 10'h3FF;
    end
    @(negedge clk);
    bus.load_valid = 1'b0;
    #1;
    chk("rstmid.pre_x_valid", bus.x_valid, 1'b1);
    chk("rstmid.pre_load_ready", bus.load_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("rstmid.x_valid", bus.x_valid, 1'b0);
    chk("rstmid.busy", bus.busy, 1'b0);
    chk("rstmid.last", bus.last, 1'b0);
    chk("rstmid.load_ready", bus.load_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    bus.load_valid = 1'b1; bus.load_data = 10'h200;
    @(negedge clk);
    bus.load_valid = 1'b0;
    #1;
    chk("rstmid.new_b0_x", bus.x, 1'b1);
    chk("rstmid.new_b0_x_valid", bus.x_valid, 1'b1);
    @(negedge clk);
    #1;
    chk("rstmid.new_b1_x", bus.x, 1'b0);
    repeat (FR - 1) @(negedge clk);
    #1;
    chk("rstmid.drain_busy", bus.busy, 1'b0);

    // LSB-first instance
    @(negedge clk);
    bus.en = 1'b0;
    bus_l.load_valid = 1'b1; bus_l.load_data = 10'b0000000001; bus_l.en = 1'b1;
    for (int k = 0; k < FR; k++) begin
      @(negedge clk);
      bus_l.load_valid = 1'b0;
      #1;
      chk($sformatf("lsb%0d.x", k), bus_l.x, pat_l[FR-1-k]);
      chk($sformatf("lsb%0d.x_valid", k), bus_l.x_valid, 1'b1);
      chk($sformatf("lsb%0d.last", k), bus_l.last, (k == FR - 1));
    end
    @(negedge clk);
    #1;
    chk("lsb.done_busy", bus_l.busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
